// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// CPU request codes, default widths and the controller state encoding.
package dm_cache_ctrl_pkg;

  localparam int DEF_WORDWIDTH    = 32;
  localparam int DEF_ADDRWIDTH    = 16;
  localparam int DEF_IOSTATEWIDTH = 2;

  // CPU request codes on rwToMem; the remaining code (3) is illegal
  localparam logic [DEF_IOSTATEWIDTH-1:0] IDEL  = 2'd0;
  localparam logic [DEF_IOSTATEWIDTH-1:0] READ  = 2'd1;
  localparam logic [DEF_IOSTATEWIDTH-1:0] WRITE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2,
    DONE    = 2'd3
  } cacheState_t;

endpackage

// File: rtl/dm_cache_array.sv
// Tag/data/valid storage for a direct-mapped, one-word-per-line cache.
// Lookup is combinational; writes (fill or write-hit update) are synchronous.
// Only the valid bits are cleared by reset; tag and data storage is not.
module dm_cache_array
  import dm_cache_ctrl_pkg::*;
#(
  parameter int WORDWIDTH  = DEF_WORDWIDTH,
  parameter int ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int INDEXWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRWIDTH-1:0] lookupAddr,
  output logic                 hit,
  output logic [WORDWIDTH-1:0] readData,
  input  logic                 writeEn,
  input  logic [ADDRWIDTH-1:0] writeAddr,
  input  logic [WORDWIDTH-1:0] writeData
);

  localparam int TAGWIDTH = ADDRWIDTH - INDEXWIDTH;
  localparam int LINES    = 1 << INDEXWIDTH;

  logic [LINES-1:0]     validBits;
  logic [TAGWIDTH-1:0]  tagMem  [LINES];
  logic [WORDWIDTH-1:0] dataMem [LINES];

  logic [INDEXWIDTH-1:0] lookupIndex;
  logic [TAGWIDTH-1:0]   lookupTag;
  logic [INDEXWIDTH-1:0] writeIndex;
  logic [TAGWIDTH-1:0]   writeTag;

  assign lookupIndex = lookupAddr[INDEXWIDTH-1:0];
  assign lookupTag   = lookupAddr[ADDRWIDTH-1:INDEXWIDTH];
  assign writeIndex  = writeAddr[INDEXWIDTH-1:0];
  assign writeTag    = writeAddr[ADDRWIDTH-1:INDEXWIDTH];

  assign hit      = validBits[lookupIndex] && (tagMem[lookupIndex] == lookupTag);
  assign readData = dataMem[lookupIndex];

  // Valid bits: cleared by reset, set on any line write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validBits <= '0;
    end else if (writeEn) begin
      validBits[writeIndex] <= 1'b1;
    end
  end

  // Tag and data storage, written on fill or write-hit update
  always_ff @(posedge clk) begin
    if (writeEn) begin
      tagMem[writeIndex]  <= writeTag;
      dataMem[writeIndex] <= writeData;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller sitting
// between the CPU memory port and a req/ack main memory. Read hits answer in
// one cycle; misses and all writes go to memory. Saturating hit/miss counters.
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
#(
  parameter int WORDWIDTH    = DEF_WORDWIDTH,
  parameter int ADDRWIDTH    = DEF_ADDRWIDTH,
  parameter int INDEXWIDTH   = 4,
  parameter int IOSTATEWIDTH = DEF_IOSTATEWIDTH,
  parameter int CNTWIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwToMem,
  input  logic [ADDRWIDTH-1:0]    addrToMem,
  input  logic [WORDWIDTH-1:0]    dataToMem,
  output logic                    rdEn,
  output logic                    wtEn,
  output logic [WORDWIDTH-1:0]    dataFromMem,
  output logic                    memReq,
  output logic                    memWe,
  output logic [ADDRWIDTH-1:0]    memAddr,
  output logic [WORDWIDTH-1:0]    memWdata,
  input  logic [WORDWIDTH-1:0]    memRdata,
  input  logic                    memAck,
  output logic                    cacheErr,
  output logic [CNTWIDTH-1:0]     hitCount,
  output logic [CNTWIDTH-1:0]     missCount
);

  cacheState_t state, stateNext;

  logic [ADDRWIDTH-1:0] addrReg;
  logic [WORDWIDTH-1:0] dataReg;

  logic                 lookupHit;
  logic [WORDWIDTH-1:0] lookupData;

  logic                 arrWriteEn;
  logic [ADDRWIDTH-1:0] arrWriteAddr;
  logic [WORDWIDTH-1:0] arrWriteData;

  logic                 rdEnNext;
  logic                 wtEnNext;
  logic                 errNext;
  logic [WORDWIDTH-1:0] dataNext;
  logic                 captureEn;
  logic                 hitInc;
  logic                 missInc;

  logic isRead, isWrite, isIdel;

  assign isRead  = (rwToMem == IOSTATEWIDTH'(READ));
  assign isWrite = (rwToMem == IOSTATEWIDTH'(WRITE));
  assign isIdel  = (rwToMem == IOSTATEWIDTH'(IDEL));

  dm_cache_array #(
    .WORDWIDTH (WORDWIDTH),
    .ADDRWIDTH (ADDRWIDTH),
    .INDEXWIDTH(INDEXWIDTH)
  ) uArray (
    .clk       (clk),
    .reset     (reset),
    .lookupAddr(addrToMem),
    .hit       (lookupHit),
    .readData  (lookupData),
    .writeEn   (arrWriteEn),
    .writeAddr (arrWriteAddr),
    .writeData (arrWriteData)
  );

  // Memory request is a pure function of state, so reset drops it at once
  assign memReq   = (state == RD_MISS) || (state == WR_MEM);
  assign memWe    = (state == WR_MEM);
  assign memAddr  = addrReg;
  assign memWdata = dataReg;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode, array write control and next values of CPU-side outputs
  always_comb begin
    stateNext    = state;
    rdEnNext     = 1'b0;
    wtEnNext     = 1'b0;
    errNext      = 1'b0;
    dataNext     = dataFromMem;
    captureEn    = 1'b0;
    hitInc       = 1'b0;
    missInc      = 1'b0;
    arrWriteEn   = 1'b0;
    arrWriteAddr = addrToMem;
    arrWriteData = dataToMem;
    case (state)
      IDLE: begin
        if (isRead) begin
          if (lookupHit) begin
            rdEnNext  = 1'b1;
            dataNext  = lookupData;
            hitInc    = 1'b1;
            stateNext = DONE;
          end else begin
            missInc   = 1'b1;
            captureEn = 1'b1;
            stateNext = RD_MISS;
          end
        end else if (isWrite) begin
          captureEn  = 1'b1;
          arrWriteEn = lookupHit;
          stateNext  = WR_MEM;
        end else if (!isIdel) begin
          errNext = 1'b1;
        end
      end
      RD_MISS: begin
        if (memAck) begin
          arrWriteEn   = 1'b1;
          arrWriteAddr = addrReg;
          arrWriteData = memRdata;
          rdEnNext     = 1'b1;
          dataNext     = memRdata;
          stateNext    = DONE;
        end
      end
      WR_MEM: begin
        if (memAck) begin
          wtEnNext  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Registered CPU-side outputs, captured request and saturating counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdEn        <= 1'b0;
      wtEn        <= 1'b0;
      cacheErr    <= 1'b0;
      dataFromMem <= '0;
      addrReg     <= '0;
      dataReg     <= '0;
      hitCount    <= '0;
      missCount   <= '0;
    end else begin
      rdEn        <= rdEnNext;
      wtEn        <= wtEnNext;
      cacheErr    <= errNext;
      dataFromMem <= dataNext;
      if (captureEn) begin
        addrReg <= addrToMem;
        dataReg <= dataToMem;
      end
      if (hitInc && (hitCount != '1)) begin
        hitCount <= hitCount + 1'b1;
      end
      if (missInc && (missCount != '1)) begin
        missCount <= missCount + 1'b1;
      end
    end
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, one-word-per-line cache between the processor's memory port and main memory.
- Processor side: consumes the processor's rwToMem/addrToMem/dataToMem request and answers with rdEn/wtEn pulses plus dataFromMem.
- Memory side: req/ack handshake.
- The cache is transparent to the CPU; only latency varies.

Parameters:
- WORDWIDTH, 32, data word width
- ADDRWIDTH, 16, word address width
- INDEXWIDTH, 4, line index bits (2^INDEXWIDTH lines); tag = ADDRWIDTH-INDEXWIDTH bits
- IOSTATEWIDTH, 2, width of the rw request code
- CNTWIDTH, 16, hit/miss counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rwToMem  in  IOSTATEWIDTH  CPU request code: IDEL=0, READ=1, WRITE=2, 3 illegal
- addrToMem  in  ADDRWIDTH  CPU word address
- dataToMem  in  WORDWIDTH  CPU write data
- rdEn  out  1  one-cycle pulse; dataFromMem valid
- wtEn  out  1  one-cycle pulse; write committed to memory
- dataFromMem  out  WORDWIDTH  read data to CPU
- memReq  out  1  memory request, held until memAck
- memWe  out  1  1 = write, 0 = read; valid while memReq
- memAddr  out  ADDRWIDTH  memory address
- memWdata  out  WORDWIDTH  memory write data
- memRdata  in  WORDWIDTH  memory read data; valid in memAck cycle
- memAck  in  1  memory completion; honoured only while memReq=1
- cacheErr  out  1  one-cycle pulse on illegal rw code
- hitCount  out  CNTWIDTH  saturating read-hit counter
- missCount  out  CNTWIDTH  saturating read-miss counter

Behaviour:
- Reset (reset=0, async): state IDLE; all valid bits cleared. Outputs rdEn, wtEn, memReq, memWe, cacheErr, hitCount and missCount go to 0; dataFromMem, memAddr and memWdata go to 0. Tag/data arrays are not reset.
- Addressing: index = addr[INDEXWIDTH-1:0]; tag = addr[ADDRWIDTH-1:INDEXWIDTH]. Hit = valid[index] && tag match.
- FSM states: IDLE, RD_MISS, WR_MEM, DONE.
- IDLE samples the request each edge:
  - READ hit: next cycle rdEn=1, dataFromMem = line data; hitCount+1; go to DONE. Latency 1.
  - READ miss: go to RD_MISS; missCount+1.
  - WRITE: go to WR_MEM. On hit, the line data is updated in the same edge. On miss, no allocate; the line is untouched.
  - Code 3: cacheErr=1 for one cycle; stay IDLE; no memory access.
  - IDEL: no action.
- Request capture: address and write data are registered on acceptance. The CPU must hold the request stable until rdEn/wtEn.
- RD_MISS:
  - memReq=1, memWe=0, memAddr = captured address, from state entry.
  - On memAck: fill the line (data, tag, valid=1); rdEn=1 with dataFromMem = memRdata next cycle; memReq drops; go to DONE.
  - Miss latency = ack wait + 1.
- WR_MEM:
  - memReq=1, memWe=1, memAddr/memWdata = captured values.
  - On memAck: wtEn=1 next cycle; memReq drops; go to DONE.
- DONE:
  - Exactly one cycle; no request sampled; go to IDLE.
  - The CPU must change or deassert its request in the cycle after rdEn/wtEn, which prevents re-triggering.
- dataFromMem holds its last value until the next read completes.
- memAck:
  - memAck in the same cycle memReq first rises is accepted.
  - memAck while memReq=0 (including in IDLE/DONE) is ignored.
- Counters saturate at all-ones and do not wrap. Writes do not count.
- Reset mid-miss: memReq drops immediately; the pending fill is discarded; a later stray memAck is ignored.
- rdEn and wtEn are never high together. memReq is never asserted in IDLE or DONE.

Decomposition:
- Shared def package holds:
  - IDEL/READ/WRITE codes
  - IOSTATEWIDTH, WORDWIDTH and ADDRWIDTH defaults
  - FSM state encoding
- One natural sub-module: dm_cache_array. It holds the tag/data/valid storage, with a combinational hit/read port and a synchronous write port. Valid-clear is wired to reset.
- The controller FSM and counters stay in dm_cache_ctrl.

Test Plan:
- Read miss then hit: READ 0x0013 with memory word 0xDEADBEEF and ack after 3 cycles -> memReq high 3 cycles, rdEn with 0xDEADBEEF, missCount=1. Repeat the READ -> rdEn 1 cycle after the request, 0xDEADBEEF, hitCount=1, no memReq.
- Conflict eviction: READ 0x0013, then READ 0x0023 (same index 3, tag differs) -> second read misses; READ 0x0013 again -> misses; missCount=3.
- Write-through with update: after 0x0013 is cached, WRITE 0x0013 with 0x12345678 -> memWe=1, memWdata=0x12345678, wtEn after ack; next READ 0x0013 hits and returns 0x12345678. WRITE to uncached 0x0045 -> READ 0x0045 then misses.
- Illegal and stray events: rwToMem=3 -> cacheErr one-cycle pulse, no memReq. memAck pulse while IDLE -> no rdEn/wtEn, no state change.
- Reset mid-miss: assert reset during RD_MISS wait, release, then ack -> memReq low, no rdEn. READ 0x0013 -> misses (valid cleared).
- Saturation: with CNTWIDTH=4, perform 17 read hits -> hitCount holds 15.
